// File: rtl/sequence_player_if.sv
// sequence_player_if: control, sequence and display signals between the
// game FSM / segment storage / flash timer side and the sequence player.
interface sequence_player_if #(
  parameter int MAX_LEN  = 32,
  parameter int COLOUR_W = 3
);
  localparam int IDX_W = $clog2(MAX_LEN);

  logic                               start;
  logic [5:0]                         round_len;
  logic [MAX_LEN-1:0][COLOUR_W-1:0]   segment;
  logic                               pulse;
  logic [3:0]                         led_o;
  logic [IDX_W-1:0]                   index_o;
  logic                               busy;
  logic                               done;

  modport master (
    output start, round_len, segment, pulse,
    input  led_o, index_o, busy, done
  );

  modport slave (
    input  start, round_len, segment, pulse,
    output led_o, index_o, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// sequence_player: plays the stored colour sequence back one entry per flash
// timer tick. The colour array is snapshotted on start so later writes to the
// segment storage cannot disturb a round in progress.
// Build option: define SEQ_PLAYER_GAP_EN to insert one dark pulse period after
// every colour (repeated colours become distinguishable); otherwise colours are
// shown back to back.
module sequence_player #(
  parameter int MAX_LEN  = 32,
  parameter int COLOUR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  sequence_player_if.slave   sif
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ON    = 3'd2,
    S_OFF   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 index_q, index_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [MAX_LEN-1:0][COLOUR_W-1:0] snap_q, snap_d;
  logic [3:0]                       led_q, led_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic [LEN_W-1:0]                 len_clamp;
  logic                             last;

  // Colours 0..3 light one LED; anything else is a dark slot.
  function automatic logic [3:0] dec(input logic [COLOUR_W-1:0] c);
    logic [3:0] r;
    case (c)
      COLOUR_W'(0): r = 4'b0001;
      COLOUR_W'(1): r = 4'b0010;
      COLOUR_W'(2): r = 4'b0100;
      COLOUR_W'(3): r = 4'b1000;
      default:      r = 4'b0000;
    endcase
    return r;
  endfunction

  assign len_clamp = (sif.round_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sif.round_len;
  assign last      = ((LEN_W'(index_q) + LEN_W'(1)) == len_q);

  // Next-state logic; outputs are derived from the next state so they register
  // in step with the state change.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d   = len_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          snap_d  = sif.segment;
          len_d   = len_clamp;
          index_d = '0;
          state_d = (len_clamp == '0) ? S_DONE : S_ALIGN;
        end
      end
      S_ALIGN: if (sif.pulse) state_d = S_ON;
`ifdef SEQ_PLAYER_GAP_EN
      S_ON: if (sif.pulse) state_d = S_OFF;
      S_OFF: begin
        if (sif.pulse) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = S_ON;
          end
        end
      end
`else
      S_ON: begin
        if (sif.pulse) begin
          if (last) state_d = S_DONE;
          else      index_d = index_q + IDX_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    led_d  = (state_d == S_ON) ? dec(snap_d[index_d]) : 4'b0000;
    busy_d = (state_d == S_ALIGN) || (state_d == S_ON) || (state_d == S_OFF);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset aborts playback without a done strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      len_q   <= '0;
      snap_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      snap_q  <= snap_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sif.led_o   = led_q;
  assign sif.index_o = index_q;
  assign sif.busy    = busy_q;
  assign sif.done    = done_q;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: scoreboard bench. Each playback pushes the expected
// {done,busy,index,led} after start and after every pulse; the driver pops one
// entry per pulse and checks it, plus holds between pulses.
module tb_sequence_player;
  localparam int MAX_LEN  = 32;
  localparam int COLOUR_W = 3;
`ifdef SEQ_PLAYER_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  typedef logic [MAX_LEN-1:0][COLOUR_W-1:0] seg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sequence_player_if #(.MAX_LEN(MAX_LEN), .COLOUR_W(COLOUR_W)) sif();

  sequence_player #(.MAX_LEN(MAX_LEN), .COLOUR_W(COLOUR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  wire [10:0] obs = {sif.done, sif.busy, sif.index_o, sif.led_o};

  function automatic logic [10:0] pk(input bit d, input bit b, input int idx, input logic [3:0] led);
    return {d, b, 5'(idx), led};
  endfunction

  function automatic logic [3:0] col(input logic [2:0] c);
    return (c < 3'd4) ? 4'(4'b0001 << c) : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_once();
    @(posedge clk); #1 sif.pulse = 1'b1;
    @(posedge clk); #1 sif.pulse = 1'b0;
  endtask

  // One playback: model pushes expectations, then the driver steps through pulses.
  task automatic play(input seg_t seg, input int rlen, input int per,
                      input bit with_pulse, input bit clobber, input bit poke);
    int len;
    logic [10:0] cur;
    len = (rlen > MAX_LEN) ? MAX_LEN : rlen;
    if (len == 0) begin
      exp_q.push_back(pk(1, 0, 0, 4'b0));
    end else begin
      exp_q.push_back(pk(0, 1, 0, 4'b0));
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(pk(0, 1, i, col(seg[i])));
        if (GAP) exp_q.push_back(pk(0, 1, i, 4'b0));
      end
      exp_q.push_back(pk(1, 0, len - 1, 4'b0));
    end

    @(posedge clk); #1;
    sif.segment   = seg;
    sif.round_len = 6'(rlen);
    sif.start     = 1'b1;
    sif.pulse     = with_pulse;
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.pulse = 1'b0;
    if (clobber) sif.segment = {MAX_LEN{3'd3}};
    cur = exp_q.pop_front();
    @(negedge clk); chk("start", obs, cur);

    while (!cur[10] && exp_q.size() > 0) begin
      for (int k = 1; k < per; k++) begin
        @(posedge clk); #1 sif.start = poke;
        @(negedge clk); chk("hold", obs, cur);
      end
      @(posedge clk); #1;
      sif.start = 1'b0;
      sif.pulse = 1'b1;
      @(posedge clk); #1 sif.pulse = 1'b0;
      cur = exp_q.pop_front();
      @(negedge clk); chk("step", obs, cur);
    end
    @(negedge clk); chk("idle", obs, {2'b00, cur[8:4], 4'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1);
  end

  initial begin
    seg_t s;
    sif.start     = 1'b0;
    sif.pulse     = 1'b0;
    sif.round_len = '0;
    sif.segment   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("reset", obs, 11'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Pulse while idle is ignored.
    pulse_once();
    @(negedge clk); chk("idle_pulse", obs, 11'h0);

    // Ascending colours, 4 entries.
    for (int i = 0; i < MAX_LEN; i++) s[i] = 3'(i % 4);
    play(s, 4, 8, 1'b0, 1'b0, 1'b0);

    // Zero-length round.
    play(s, 0, 4, 1'b0, 1'b0, 1'b0);

    // Over-long round clamps to 32, all colour 2.
    for (int i = 0; i < MAX_LEN; i++) s[i] = 3'd2;
    play(s, 40, 2, 1'b0, 1'b0, 1'b0);

    // Start with coincident pulse, segment clobbered mid-playback, dark codes.
    for (int i = 0; i < MAX_LEN; i++) s[i] = 3'((i * 5 + 1) % 8);
    play(s, 6, 5, 1'b1, 1'b1, 1'b0);

    // Repeated colours; start pokes during playback must be ignored.
    s = '0;
    s[0] = 3'd1; s[1] = 3'd1; s[2] = 3'd3;
    play(s, 3, 6, 1'b0, 1'b0, 1'b1);

    // Reset during the third lit period.
    for (int i = 0; i < MAX_LEN; i++) s[i] = 3'((i + 1) % 4);
    @(posedge clk); #1;
    sif.segment   = s;
    sif.round_len = 6'd5;
    sif.start     = 1'b1;
    @(posedge clk); #1 sif.start = 1'b0;
    repeat (GAP ? 5 : 3) begin
      repeat (3) @(posedge clk);
      pulse_once();
    end
    @(negedge clk); chk("on3", obs, pk(0, 1, 2, col(s[2])));
    #2 reset = 1'b1;
    #1 chk("rst_async", obs, 11'h0);
    repeat (4) begin
      @(negedge clk); chk("rst_hold", obs, 11'h0);
    end
    @(posedge clk); #1 reset = 1'b0;
    play(s, 5, 3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sequence_player.md
# sequence_player

Plays the stored Simon Says colour sequence back to the player, one colour per timer tick, during the flash phase of each round. It sits between the segment storage / flash timer and the LED display path. It snapshots the colour array when the game FSM starts playback, and steps through the first `round_len` entries on `pulse` ticks from the variable flash timer. It drives a one-hot 4-bit LED pattern and reports completion so the FSM can hand control to the player.

## Interface
- `MAX_LEN`, 32: sequence depth (entries in `segment`); index width is $clog2(MAX_LEN).
- `COLOUR_W`, 3: bits per stored colour entry.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin playback; honoured only in IDLE.
- `round_len`  in  6  number of entries to play, 0..63.
- `segment`  in  MAX_LEN×COLOUR_W  packed colour array, entry 0 played first.
- `pulse`  in  1  one-cycle tick from the flash timer.
- `led_o`  out  4  one-hot colour display, registered.
- `index_o`  out  5  index of the entry currently lit or last lit.
- `busy`  out  1  high in ALIGN, ON, OFF.
- `done`  out  1  one-cycle completion strobe.

## Operation
- States: IDLE, ALIGN, ON, OFF, DONE.
- IDLE, `start`=1:
  - Snapshot `segment` into an internal array.
  - Latch len = min(`round_len`, MAX_LEN).
  - Set index=0.
  - Next state is ALIGN, or DONE if len=0.
- ALIGN: wait for `pulse`, then go to ON. This aligns the first flash to a full timer period.
- ON: `led_o` shows the decoded colour of snapshot[index]. On `pulse`, go to OFF.
- OFF: `led_o`=0. On `pulse`:
  - if index==len-1, go to DONE;
  - otherwise index+1 and go to ON.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Colour decode: 0→4'b0001, 1→4'b0010, 2→4'b0100, 3→4'b1000. Values 4..7 give 4'b0000; they are lit as dark and still consume a slot.
- `start` outside IDLE is ignored; no queueing.
- `pulse` in IDLE and DONE is ignored.
- `segment` changes after `start` have no effect on the current playback.
- There is no abort input. The FSM aborts by asserting `reset`.

## Timing
- Reset values: state IDLE, `led_o`=0, `index_o`=0, `busy`=0, `done`=0, snapshot and len cleared.
- All outputs are registered. `led_o` changes in the cycle after the `pulse` edge that causes the transition.
- `busy` rises the cycle after the accepted `start`. It falls in the same cycle `done` rises.
- `start` and `pulse` in the same IDLE cycle: `start` is accepted and the pulse is not counted. ALIGN waits for the next pulse.
- Pulses consumed with the gap feature enabled: 1 + 2·len. `done` is high the cycle after the final pulse.
- len=0: `done` is high the cycle after `start`, and `busy` never rises.
- `round_len`>32 is clamped to 32. index never exceeds len-1, so there is no wrap-around.
- Reset asserted mid-playback: all outputs clear asynchronously and no `done` is issued.
- Back-to-back rounds: `start` in the cycle after `done` (state IDLE) is accepted.

## Configuration
- `SEQ_PLAYER_GAP_EN` defined:
  - ON/OFF alternation as above.
  - Each colour is followed by one dark pulse period, so repeated colours are distinguishable.
- Not defined:
  - OFF state removed; ON goes directly to the next ON (index+1) or to DONE on `pulse`.
  - Pulses consumed: 1 + len.
  - Repeated colours appear as one continuous flash.

## Test plan
- Reset with gap enabled, segment = {0,1,2,3,...}, round_len=4, start, pulse every 8 cycles:
  - `led_o` sequence is 0001,0000,0010,0000,0100,0000,1000,0000;
  - `index_o` steps 0..3;
  - `done` is high one cycle after pulse 9;
  - `busy` is high throughout, then drops.
- round_len=0, start → `done` one cycle later, `busy` stays 0, `led_o` stays 0.
- round_len=40, all entries colour 2 → exactly 32 lit periods of 0100, `index_o` reaches 31, then `done`.
- `start` and `pulse` in the same cycle, then `segment` overwritten to all 3 mid-playback:
  - the first lit colour appears only after the next pulse;
  - the original snapshot colours are still shown.
- Reset asserted during the third ON period:
  - `led_o`=0, `busy`=0, `index_o`=0 immediately, with no `done`;
  - a new `start` after reset plays from index 0.
- Gap disabled, segment = {1,1,3}, round_len=3 → `led_o` is 0010 for 2 pulse periods, then 1000, then `done` after pulse 4.
